// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: mode encodings shared by the waveform generator
package wave_gen_pkg;
   typedef logic [1:0] mode_t;
   localparam mode_t MODE_SAW    = 2'd0;
   localparam mode_t MODE_TRI    = 2'd1;
   localparam mode_t MODE_SQUARE = 2'd2;
   localparam mode_t MODE_PULSE  = 2'd3;
endpackage

// File: rtl/wave_phase_acc.sv
// wave_phase_acc: phase accumulator with enable gating and wrap detection
module wave_phase_acc #(
   parameter int PHASE_W = 16,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] step_i,
   output logic [DATA_W:0]    phase_o,
   output logic               carry_o,
   output logic               wrap_o
);
   logic [PHASE_W:0]   sum;
   logic [PHASE_W-1:0] acc_q, acc_d;
   logic               wrap_q, wrap_d;
   assign sum     = {1'b0, acc_q} + {1'b0, step_i};
   assign carry_o = en & sum[PHASE_W];
   assign phase_o = acc_q[PHASE_W-1 -: DATA_W+1];
   assign wrap_o  = wrap_q;
   // Next phase and wrap strobe; idle cycles hold phase and clear the strobe
   always_comb begin
      acc_d  = en ? sum[PHASE_W-1:0] : acc_q;
      wrap_d = carry_o;
   end
   // Phase and strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         wrap_q <= wrap_d;
      end
   end
endmodule

// File: rtl/wave_gen.sv
// wave_gen: multi-mode DDS waveform generator with wrap-aligned mode switching
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] step_i,
   input  mode_t              mode_i,
   input  logic [DATA_W-1:0]  duty_i,
   output logic [DATA_W-1:0]  wave_o,
   output logic               wrap_o,
   output mode_t              mode_o
);
   localparam logic [DATA_W-1:0] ONES = '1;
   localparam logic [DATA_W-1:0] ZERO = '0;
   logic [DATA_W:0]   phase;
   logic              carry;
   logic              msb;
   logic [DATA_W-1:0] p, t, f;
   logic [DATA_W-1:0] wave_q, wave_d;
   mode_t             mode_q, mode_d;
   wave_phase_acc #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .step_i (step_i),
      .phase_o(phase),
      .carry_o(carry),
      .wrap_o (wrap_o)
   );
   assign msb    = phase[DATA_W];
   assign p      = phase[DATA_W -: DATA_W];
   assign t      = phase[DATA_W-1:0];
   assign wave_o = wave_q;
   assign mode_o = mode_q;
   // Sample function of the pre-update phase in the active mode; mode only changes at a wrap or while idle
   always_comb begin
      f = mode_q == MODE_SAW    ? p :
          mode_q == MODE_TRI    ? (msb ? ~t : t) :
          mode_q == MODE_SQUARE ? (msb ? ZERO : ONES) :
                                  ((p < duty_i) ? ONES : ZERO);
      wave_d = en ? f : wave_q;
      mode_d = (!en || carry) ? mode_i : mode_q;
   end
   // Sample and active-mode registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wave_q <= '0;
         mode_q <= MODE_SAW;
      end else begin
         wave_q <= wave_d;
         mode_q <= mode_d;
      end
   end
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed and random stimulus against an arithmetic waveform model
module tb_wave_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] step_i = '0;
   logic [1:0]  mode_i = '0;
   logic [7:0]  duty_i = '0;
   logic [7:0]  wave_o;
   logic        wrap_o;
   logic [1:0]  mode_o;
   int errors = 0;
   int checks = 0;
   int ph = 0;
   int wv = 0;
   int wr = 0;
   int md = 0;

   wave_gen dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .step_i(step_i),
      .mode_i(mode_i),
      .duty_i(duty_i),
      .wave_o(wave_o),
      .wrap_o(wrap_o),
      .mode_o(mode_o)
   );

   always #5 clk = ~clk;

   // Ideal sample for a 16-bit phase value, computed from the waveform shapes
   function automatic int fm(input int phase, input int m, input int d);
      int pos, tri_x;
      pos   = phase / 256;
      tri_x = (phase / 128) % 256;
      case (m)
         0:       return pos;
         1:       return (phase >= 32768) ? 255 - tri_x : tri_x;
         2:       return (phase >= 32768) ? 0 : 255;
         default: return (pos < d) ? 255 : 0;
      endcase
   endfunction

   task automatic cyc(input bit r, input bit e, input int s, input int m, input int d);
      int sum;
      rst    = r;
      en     = e;
      step_i = 16'(s);
      mode_i = 2'(m);
      duty_i = 8'(d);
      @(posedge clk);
      if (r) begin
         ph = 0; wv = 0; wr = 0; md = 0;
      end else if (e) begin
         wv  = fm(ph, md, d);
         sum = ph + s;
         wr  = (sum >= 65536) ? 1 : 0;
         if (wr == 1) md = m;
         ph  = sum % 65536;
      end else begin
         wr = 0;
         md = m;
      end
      #1;
      checks += 3;
      assert (wave_o === 8'(wv)) else begin
         errors++;
         $error("FAIL wave t=%0t got=%0d exp=%0d", $time, wave_o, wv);
      end
      assert (wrap_o === 1'(wr)) else begin
         errors++;
         $error("FAIL wrap t=%0t got=%0b exp=%0d", $time, wrap_o, wr);
      end
      assert (mode_o === 2'(md)) else begin
         errors++;
         $error("FAIL mode t=%0t got=%0d exp=%0d", $time, mode_o, md);
      end
   endtask

   initial begin
      int m, d, s;
      // reset, then SAW ramp over more than one period
      cyc(1, 1, 256, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) cyc(0, 1, 256, 0, 0);
      // TRI selected while idle after reset
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 256, 1, 0);
      for (int i = 0; i < 260; i++) cyc(0, 1, 256, 1, 0);
      // PULSE duty 64, then duty 0 and duty 255 boundaries
      cyc(0, 0, 256, 3, 64);
      for (int i = 0; i < 300; i++) cyc(0, 1, 256, 3, 64);
      for (int i = 0; i < 260; i++) cyc(0, 1, 256, 3, 0);
      for (int i = 0; i < 260; i++) cyc(0, 1, 256, 3, 255);
      // SAW to 0x4000, then request SQUARE; switch lands at the wrap
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) cyc(0, 1, 256, 0, 0);
      for (int i = 0; i < 300; i++) cyc(0, 1, 256, 2, 0);
      // idle hold mid-ramp with mode changing, then resume
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 1, 256, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 256, 0, 0);
      cyc(0, 0, 256, 1, 0);
      for (int i = 0; i < 200; i++) cyc(0, 1, 256, 1, 0);
      // step 0 freezes phase and never wraps
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 2, 0);
      // reset mid-period with en held, then restart
      for (int i = 0; i < 30; i++) cyc(0, 1, 256, 0, 0);
      cyc(1, 1, 256, 2, 0);
      for (int i = 0; i < 260; i++) cyc(0, 1, 256, 0, 0);
      // random stimulus
      m = 0; d = 0; s = 1000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) m = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) d = $urandom_range(0, 255);
         if ($urandom_range(0, 99) == 0) s = $urandom_range(0, 65535);
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, s, m, d);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wave_gen.md
Name: wave_gen

Overview:
Parametrised multi-mode digital waveform generator (DDS-style) for the lab DAC/scope path. It is built on a phase accumulator with a run-time frequency tuning word.
- Produces sawtooth, symmetric triangle, square or variable-duty pulse at DATA_W bits.
- Mode changes take effect only at a phase wrap, so the output never glitches mid-period.
- Drives the DAC sample register directly; wrap_o serves as a period marker for the scope trigger.

Parameters:
PHASE_W, 16, phase accumulator width; must be >= DATA_W+1
DATA_W, 8, output sample width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  advance phase this cycle; hold all state when 0
step_i  in  PHASE_W  frequency tuning word, added to phase each enabled cycle
mode_i  in  2  requested mode: 0 SAW, 1 TRI, 2 SQUARE, 3 PULSE
duty_i  in  DATA_W  pulse threshold (PULSE mode)
wave_o  out  DATA_W  registered sample
wrap_o  out  1  one-cycle strobe on phase overflow
mode_o  out  2  currently active mode

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: acc=0, wave_o=0, wrap_o=0, mode_o=SAW. Reset overrides en and all other inputs, including when asserted mid-period.
- Accumulator: when en=1, acc <= (acc + step_i) mod 2^PHASE_W. The carry out of that sum sets wrap_o=1 for that cycle; otherwise wrap_o=0.
- step_i is used the cycle it is presented; no staging. step_i=0 freezes phase with en=1 and never wraps.
- Phase fields, taken from the current (pre-update) acc:
  - p = acc[PHASE_W-1 -: DATA_W]
  - msb = acc[PHASE_W-1]
  - t = acc[PHASE_W-2 -: DATA_W]
- Sample function f, applied in the active mode:
  - SAW: p
  - TRI: msb ? ~t : t
  - SQUARE: msb ? 0 : all-ones
  - PULSE: (p < duty_i) ? all-ones : 0. duty_i=0 gives constant 0; duty_i=all-ones gives all-ones except at p=all-ones.
- When en=1: wave_o <= f(acc, mode_o). Latency is one cycle from phase to sample.
- When en=0: acc, wave_o and mode_o hold; wrap_o=0.
- Mode switching:
  - mode_o <= mode_i on any enabled cycle whose sum carries (the wrap cycle). The new mode governs samples from the next cycle.
  - mode_o <= mode_i on any cycle with en=0, so an idle generator switches immediately.
  - If mode_i changes repeatedly before a wrap, only the value present at the wrap cycle is taken.
- duty_i is used live, without staging.
- All arithmetic is unsigned; overflow wraps silently, and a wrap is the only overflow event.

Decomposition:
- Package wave_gen_pkg holds the mode encodings (MODE_SAW=0, MODE_TRI=1, MODE_SQUARE=2, MODE_PULSE=3) and a 2-bit mode typedef.
- Sub-module wave_phase_acc holds the accumulator register, en gating and carry/wrap detection.
- Field extraction, f and mode staging stay in wave_gen.

Test Plan:
Defaults throughout (PHASE_W=16, DATA_W=8).
1. Reset, en=1, SAW, step=256 -> wave_o = 0,1,2,…,255,0; wrap_o high once every 256 cycles, coincident with acc 0xFF00 -> 0x0000.
2. TRI, step=256 (mode applied at reset idle) -> wave_o = 0,2,4,…,254,255,253,…,1,0; period 256 cycles, peak 255.
3. PULSE, duty=64, step=256 -> wave_o = 255 for 64 cycles, then 0 for 192 cycles, repeating; duty=0 gives constant 0.
4. Running SAW at acc=0x4000, mode_i switched to SQUARE -> wave_o continues the ramp to 255. First SQUARE sample (255) comes the cycle after the wrap; mode_o updates on the wrap cycle.
5. en=0 for 10 cycles mid-ramp, then mode_i=TRI -> wave_o, acc and wrap_o frozen/0 during the hold; mode_o=TRI the next cycle. With en=1 again, the ramp resumes from the held phase.
6. rst asserted for 1 cycle mid-period with en=1 -> next cycle wave_o=0, mode_o=SAW, wrap_o=0; the sequence restarts as in scenario 1.
